branch_predict_unit: RTL

//  Fetch-stage branch predictor for the pipelined MIPS core: direct-mapped BTB plus 2-bit saturating counters.

---
 rtl/mips_bp_pkg.sv | 39 +++
 rtl/bp_ras.sv | 57 +++++
 rtl/branch_predict_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mips_bp_pkg.sv
// Shared types for the fetch-stage branch predictor: entry layout, control-flow
// kinds and 2-bit saturating counter helpers.
package mips_bp_pkg;

  localparam int unsigned BP_ADDR_W = 32;

  typedef enum logic [1:0] {
    BP_COND = 2'd0,
    BP_JUMP = 2'd1,
    BP_CALL = 2'd2,
    BP_RET  = 2'd3
  } bp_type_e;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Tag is held zero-extended so one entry layout serves any index width.
  typedef struct packed {
    logic                 valid;
    logic [BP_ADDR_W-1:0] tag;
    logic [BP_ADDR_W-1:0] target;
    logic [1:0]           ctr;
    bp_type_e             br_type;
  } bp_entry_t;

  function automatic logic [1:0] sat_ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && (ctr != CTR_ST)) begin
      nxt = ctr + 2'd1;
    end else if (!taken && (ctr != CTR_SNT)) begin
      nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// a pop when empty is ignored and the exposed top reads as zero.
module bp_ras #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [AW-1:0] push_data_i,
  output logic [AW-1:0] top_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [AW-1:0]    stack_q [DEPTH];
  logic [PTR_W-1:0] sp_q, sp_d, top_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign top_idx = (sp_q == '0) ? LAST : sp_q - PTR_W'(1);
  assign top_c   = (cnt_q != '0) ? stack_q[top_idx] : '0;

  // sp_q is the next write slot; cnt_q tracks occupancy up to DEPTH
  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (push_i) begin
      sp_d = (sp_q == LAST) ? '0 : sp_q + PTR_W'(1);
      if (cnt_q != CNT_W'(DEPTH)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (pop_i && (cnt_q != '0)) begin
      sp_d  = top_idx;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      if (push_i) begin
        stack_q[sp_q] <= push_data_i;
      end
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Fetch-stage predictor: direct-mapped BTB with 2-bit counters, trained from EX/MEM.
// Define BP_RAS_EN to add a return-address stack for RET prediction (ADDR_WIDTH <= 32).
module branch_predict_unit
  import mips_bp_pkg::*;
#(
  parameter int unsigned ENTRIES    = 16,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [1:0]  CTR_ALLOC  = 2'b10,
  parameter int unsigned RAS_DEPTH  = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] fetch_pc,
  input  logic                  fetch_valid,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] pred_target,
  input  logic                  upd_valid,
  input  logic [ADDR_WIDTH-1:0] upd_pc,
  input  logic [1:0]            upd_type,
  input  logic                  upd_taken,
  input  logic [ADDR_WIDTH-1:0] upd_target,
  input  logic                  upd_pred_taken,
  input  logic [ADDR_WIDTH-1:0] upd_pred_target,
  input  logic                  flush_all,
  output logic                  mispredict,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [CNT_WIDTH-1:0]  mispredict_count
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam bp_entry_t RST_ENTRY = '{valid: 1'b0, tag: '0, target: '0,
                                      ctr: CTR_WNT, br_type: BP_COND};

  bp_entry_t entries_q [ENTRIES];
  bp_entry_t entries_d [ENTRIES];
  logic [CNT_WIDTH-1:0] mp_cnt_q, mp_cnt_d;

  logic [IDX_W-1:0]      f_idx, u_idx;
  logic [BP_ADDR_W-1:0]  f_tag, u_tag;
  logic                  f_hit, u_hit;
  bp_type_e              f_type, upd_kind;
  logic [ADDR_WIDTH-1:0] f_seq, f_btb_tgt;

  assign f_idx     = fetch_pc[IDX_W+1:2];
  assign f_tag     = BP_ADDR_W'(fetch_pc[ADDR_WIDTH-1:IDX_W+2]);
  assign f_hit     = entries_q[f_idx].valid && (entries_q[f_idx].tag == f_tag);
  assign f_type    = entries_q[f_idx].br_type;
  assign f_btb_tgt = ADDR_WIDTH'(entries_q[f_idx].target);
  assign f_seq     = fetch_pc + ADDR_WIDTH'(4);

  assign u_idx    = upd_pc[IDX_W+1:2];
  assign u_tag    = BP_ADDR_W'(upd_pc[ADDR_WIDTH-1:IDX_W+2]);
  assign u_hit    = entries_q[u_idx].valid && (entries_q[u_idx].tag == u_tag);
  assign upd_kind = bp_type_e'(upd_type);

`ifdef BP_RAS_EN
  logic                  ras_push, ras_pop;
  logic [ADDR_WIDTH-1:0] ras_top;

  assign ras_push = f_hit && fetch_valid && (f_type == BP_CALL);
  assign ras_pop  = f_hit && fetch_valid && (f_type == BP_RET);

  bp_ras #(
    .DEPTH (RAS_DEPTH),
    .AW    (ADDR_WIDTH)
  ) u_ras (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (f_seq),
    .top_c       (ras_top)
  );
`else
  localparam int unsigned unused_ras_depth = RAS_DEPTH;
  logic unused_fetch_valid;
  assign unused_fetch_valid = fetch_valid;
`endif

  // Zero-latency lookup from pre-edge table contents
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = f_seq;
    if (f_hit) begin
      if (f_type == BP_COND) begin
        if (entries_q[f_idx].ctr[1]) begin
          pred_taken  = 1'b1;
          pred_target = f_btb_tgt;
        end
      end else begin
        pred_taken  = 1'b1;
        pred_target = f_btb_tgt;
`ifdef BP_RAS_EN
        if (f_type == BP_RET) begin
          pred_target = ras_top;
        end
`endif
      end
    end
  end

  assign mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                       (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + ADDR_WIDTH'(4);
  assign mispredict_count = mp_cnt_q;

  // Training; a flush wins over a same-cycle update
  always_comb begin
    entries_d = entries_q;
    mp_cnt_d  = mp_cnt_q;
    if (mispredict && (mp_cnt_q != '1)) begin
      mp_cnt_d = mp_cnt_q + CNT_WIDTH'(1);
    end
    if (flush_all) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        entries_d[i].valid = 1'b0;
      end
    end else if (upd_valid) begin
      if (u_hit) begin
        entries_d[u_idx].ctr = (entries_q[u_idx].br_type == BP_COND) ?
                               sat_ctr_next(entries_q[u_idx].ctr, upd_taken) : CTR_ST;
        if (upd_taken) begin
          entries_d[u_idx].target = BP_ADDR_W'(upd_target);
        end
      end else if (upd_taken) begin
        entries_d[u_idx] = '{valid:   1'b1,
                             tag:     u_tag,
                             target:  BP_ADDR_W'(upd_target),
                             ctr:     (upd_kind == BP_COND) ? CTR_ALLOC : CTR_ST,
                             br_type: upd_kind};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mp_cnt_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        entries_q[i] <= RST_ENTRY;
      end
    end else begin
      mp_cnt_q  <= mp_cnt_d;
      entries_q <= entries_d;
    end
  end

endmodule
